alu_share_arbiter: RTL and testbench

- Parametrised successor to the fixed two-input key multiplexer in front of the shared alu32.
- Accepts operation requests from NCLIENTS clients and arbitrates them round-robin onto the single keyed ALU issue port, at most one issue per cycle.
- Tags each issued operation with a client key and routes each returning ALU result back to its owner.
- Enforces one outstanding operation per client and flags protocol errors; sits between speedblock/PID consumers and alu32.

---
 rtl/alu_share_arbiter_pkg.sv | 25 ++
 rtl/alu_share_arbiter_rr.sv | 49 ++++
 rtl/alu_share_arbiter.sv | 119 +++++++++++
 tb/tb_alu_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared configuration for the keyed ALU front end: bus widths, opcodes and the idle key.
package alu_share_arbiter_pkg;

  localparam int DEF_KEY_SIZE     = 8;
  localparam int DEF_OPCODE_SIZE  = 4;
  localparam int DEF_OPERAND_SIZE = 32;

  // Key 0 on either side of the ALU means "nothing here this cycle".
  localparam int KEY_IDLE = 0;

  typedef enum logic [DEF_OPCODE_SIZE-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6
  } alu_op_e;

  function automatic int clientKey(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin arbiter: grants the first unmasked requester at or above the pointer.
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          i_en,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_elig;
  int            w_cand;

  assign w_elig = i_req & ~i_mask;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < N; i++) begin
      w_cand = (int'(r_ptr) + i >= N) ? int'(r_ptr) + i - N : int'(r_ptr) + i;
      if (i_en && !o_valid && w_elig[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = IW'(w_cand);
        o_grant[w_cand] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one keyed ALU port among NCLIENTS clients; client n issues with key n+1 and
// gets its result routed back by key, with one operation in flight per client.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NCLIENTS     = 4,
  parameter int KEY_SIZE     = DEF_KEY_SIZE,
  parameter int OPCODE_SIZE  = DEF_OPCODE_SIZE,
  parameter int OPERAND_SIZE = DEF_OPERAND_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             en,
  input  logic [NCLIENTS-1:0]              req_i,
  input  logic [NCLIENTS*OPCODE_SIZE-1:0]  op_i,
  input  logic [NCLIENTS*OPERAND_SIZE-1:0] A_i,
  input  logic [NCLIENTS*OPERAND_SIZE-1:0] B_i,
  output logic [NCLIENTS-1:0]              ack_o,
  output logic [NCLIENTS-1:0]              rsp_valid_o,
  output logic [OPERAND_SIZE-1:0]          rsp_O_o,
  output logic [NCLIENTS-1:0]              busy_o,
  output logic [OPCODE_SIZE-1:0]           alu_op_o,
  output logic [KEY_SIZE-1:0]              alu_key_o,
  output logic [OPERAND_SIZE-1:0]          alu_A_o,
  output logic [OPERAND_SIZE-1:0]          alu_B_o,
  input  logic [KEY_SIZE-1:0]              alu_key_i,
  input  logic [OPERAND_SIZE-1:0]          alu_O_i,
  output logic                             err_o
);

  localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  logic [NCLIENTS-1:0]     r_busy, r_ack, r_rspValid;
  logic [NCLIENTS-1:0]     w_gnt, w_busyNext;
  logic [IW-1:0]           w_gIdx, w_retIdx;
  logic                    w_gValid, w_retHit, w_retBad;
  logic [KEY_SIZE-1:0]     r_key;
  logic [OPCODE_SIZE-1:0]  r_op;
  logic [OPERAND_SIZE-1:0] r_A, r_B, r_rspO;
  logic                    r_err;

  // Masking with r_ack keeps a client from winning again while it drops req after its ack.
  rr_arbiter #(.N(NCLIENTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_en    (en & ~clr),
    .i_req   (req_i),
    .i_mask  (r_busy | r_ack),
    .o_grant (w_gnt),
    .o_idx   (w_gIdx),
    .o_valid (w_gValid)
  );

  always_comb begin
    w_retHit = 1'b0;
    w_retBad = 1'b0;
    w_retIdx = '0;
    if (alu_key_i != KEY_SIZE'(KEY_IDLE)) begin
      if (alu_key_i > KEY_SIZE'(NCLIENTS)) begin
        w_retBad = 1'b1;
      end else begin
        w_retIdx = IW'(alu_key_i - KEY_SIZE'(1));
        w_retHit = r_busy[w_retIdx] & ~clr;
      end
    end
  end

  // A return and a grant never touch the same client, since grants require ~busy.
  always_comb begin
    w_busyNext = r_busy;
    if (w_retHit) w_busyNext[w_retIdx] = 1'b0;
    w_busyNext = w_busyNext | w_gnt;
    if (clr) w_busyNext = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_ack      <= '0;
      r_rspValid <= '0;
      r_key      <= '0;
      r_op       <= '0;
      r_A        <= '0;
      r_B        <= '0;
      r_rspO     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busyNext;
      r_ack      <= w_gnt;
      r_rspValid <= '0;
      if (w_gValid) begin
        r_key <= KEY_SIZE'(w_gIdx) + KEY_SIZE'(1);
        r_op  <= op_i[w_gIdx*OPCODE_SIZE +: OPCODE_SIZE];
        r_A   <= A_i[w_gIdx*OPERAND_SIZE +: OPERAND_SIZE];
        r_B   <= B_i[w_gIdx*OPERAND_SIZE +: OPERAND_SIZE];
      end else begin
        r_key <= KEY_SIZE'(KEY_IDLE);
      end
      if (w_retHit) begin
        r_rspValid[w_retIdx] <= 1'b1;
        r_rspO               <= alu_O_i;
      end
      if (w_retBad) r_err <= 1'b1;
    end
  end

  assign ack_o       = r_ack;
  assign rsp_valid_o = r_rspValid;
  assign rsp_O_o     = r_rspO;
  assign busy_o      = r_busy;
  assign alu_op_o    = r_op;
  assign alu_key_o   = r_key;
  assign alu_A_o     = r_A;
  assign alu_B_o     = r_B;
  assign err_o       = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the bench plays both the clients and the ALU.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int KS = DEF_KEY_SIZE;
  localparam int OS = DEF_OPCODE_SIZE;
  localparam int DS = DEF_OPERAND_SIZE;

  typedef struct {
    logic [KS-1:0] key;
    logic [OS-1:0] op;
    logic [DS-1:0] a;
    logic [DS-1:0] b;
  } issue_t;

  typedef struct {
    logic [N-1:0]  vec;
    logic [DS-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst, clr, en, monOn;
  logic [N-1:0]  req;
  logic [OS-1:0] cliOp [N];
  logic [DS-1:0] cliA [N];
  logic [DS-1:0] cliB [N];
  logic [N*OS-1:0] opBus;
  logic [N*DS-1:0] aBus, bBus;
  logic [N-1:0]  ack_o, rsp_valid_o, busy_o;
  logic [DS-1:0] rsp_O_o, alu_A_o, alu_B_o, aluO;
  logic [OS-1:0] alu_op_o;
  logic [KS-1:0] alu_key_o, aluKey;
  logic          err_o;

  issue_t issueQ[$];
  rsp_t   rspQ[$];
  int     checkCount = 0;
  int     passCount  = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign opBus[g*OS +: OS] = cliOp[g];
    assign aBus[g*DS +: DS]  = cliA[g];
    assign bBus[g*DS +: DS]  = cliB[g];
  end

  alu_share_arbiter #(.NCLIENTS(N), .KEY_SIZE(KS), .OPCODE_SIZE(OS), .OPERAND_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .req_i(req),
    .op_i(opBus), .A_i(aBus), .B_i(bBus),
    .ack_o(ack_o), .rsp_valid_o(rsp_valid_o), .rsp_O_o(rsp_O_o), .busy_o(busy_o),
    .alu_op_o(alu_op_o), .alu_key_o(alu_key_o), .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
    .alu_key_i(aluKey), .alu_O_i(aluO), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic [OS-1:0] op, input logic [DS-1:0] a,
                               input logic [DS-1:0] b);
    cliOp[c] = op;
    cliA[c]  = a;
    cliB[c]  = b;
    req[c]   = 1'b1;
    issueQ.push_back('{KS'(c + 1), op, a, b});
  endtask

  task automatic expectRsp(input int c, input logic [DS-1:0] data);
    rspQ.push_back('{N'(1) << c, data});
  endtask

  task automatic aluReturn(input logic [KS-1:0] key, input logic [DS-1:0] data);
    aluKey = key;
    aluO   = data;
    tick();
    aluKey = '0;
  endtask

  task automatic waitAck(input int c);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_o[c]) break;
    end
    checkOutput($sformatf("ack client %0d", c), 64'(ack_o[c]), 64'(1));
    req[c] = 1'b0;
  endtask

  // Monitor: every issue and every response the DUT presents must match the next expectation.
  always @(negedge clk) begin
    issue_t ei;
    rsp_t   er;
    if (monOn) begin
      if (alu_key_o !== '0) begin
        if (issueQ.size() == 0) begin
          checkOutput("unexpected issue key", 64'(alu_key_o), 64'(0));
        end else begin
          ei = issueQ.pop_front();
          checkOutput("issue key", 64'(alu_key_o), 64'(ei.key));
          checkOutput("issue op", 64'(alu_op_o), 64'(ei.op));
          checkOutput("issue A", 64'(alu_A_o), 64'(ei.a));
          checkOutput("issue B", 64'(alu_B_o), 64'(ei.b));
          checkOutput("issue ack", 64'(ack_o), 64'(N'(1) << (ei.key - 1)));
        end
      end
      if (rsp_valid_o !== '0) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpected rsp_valid", 64'(rsp_valid_o), 64'(0));
        end else begin
          er = rspQ.pop_front();
          checkOutput("rsp valid", 64'(rsp_valid_o), 64'(er.vec));
          checkOutput("rsp data", 64'(rsp_O_o), 64'(er.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; monOn = 1'b0; req = '0;
    aluKey = '0; aluO = '0;
    for (int n = 0; n < N; n++) begin
      cliOp[n] = '0; cliA[n] = '0; cliB[n] = '0;
    end
    repeat (3) tick();
    checkOutput("reset key", 64'(alu_key_o), 64'(0));
    checkOutput("reset ack", 64'(ack_o), 64'(0));
    checkOutput("reset rsp_valid", 64'(rsp_valid_o), 64'(0));
    checkOutput("reset busy", 64'(busy_o), 64'(0));
    checkOutput("reset err", 64'(err_o), 64'(0));
    checkOutput("reset rsp_O", 64'(rsp_O_o), 64'(0));
    rst = 1'b0;
    monOn = 1'b1;

    $display("[TB] single client ADD");
    applyStimulus(1, OP_ADD, 32'hffc6b000, 32'hffd4d800);
    waitAck(1);
    checkOutput("single busy", 64'(busy_o), 64'(4'b0010));
    tick();
    expectRsp(1, 32'hff9b8800);
    aluReturn(8'd2, 32'hff9b8800);
    checkOutput("single rsp_valid", 64'(rsp_valid_o), 64'(4'b0010));
    checkOutput("single busy cleared", 64'(busy_o), 64'(0));

    $display("[TB] fairness with echo ALU");
    clr = 1'b1; tick(); clr = 1'b0;
    for (int n = 0; n < N; n++) begin
      cliOp[n] = OP_XOR;
      cliA[n]  = 32'h11111111 * (n + 1);
      cliB[n]  = 32'h0f0f0f0f;
    end
    for (int k = 0; k < 8; k++) begin
      issueQ.push_back('{KS'(k % N + 1), cliOp[k % N], cliA[k % N], cliB[k % N]});
      expectRsp(k % N, cliA[k % N] ^ cliB[k % N]);
    end
    req = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      aluKey = alu_key_o;
      aluO   = alu_A_o ^ alu_B_o;
    end
    req = '0;
    tick();
    aluKey = '0;
    tick();
    checkOutput("fairness drained", 64'(busy_o), 64'(0));

    $display("[TB] outstanding limit");
    applyStimulus(0, OP_MUL, 32'hffc6b000, 32'hffd4d800);
    waitAck(0);
    applyStimulus(0, OP_ADD, 32'h00000005, 32'h00000007);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no second issue", 64'(ack_o[0]), 64'(0));
    end
    checkOutput("client0 still busy", 64'(busy_o[0]), 64'(1));
    expectRsp(0, 32'h09a96480);
    aluReturn(8'd1, 32'h09a96480);
    checkOutput("mul rsp_valid", 64'(rsp_valid_o), 64'(4'b0001));
    checkOutput("no ack with rsp", 64'(ack_o), 64'(0));
    tick();
    checkOutput("reissue after rsp", 64'(ack_o), 64'(4'b0001));
    req[0] = 1'b0;
    expectRsp(0, 32'h0000000c);
    aluReturn(8'd1, 32'h0000000c);
    checkOutput("outstanding drained", 64'(busy_o), 64'(0));

    $display("[TB] simultaneous return and grant");
    applyStimulus(2, OP_SUB, 32'h00000100, 32'h00000001);
    waitAck(2);
    applyStimulus(3, OP_AND, 32'hf0f0f0f0, 32'h0ff00ff0);
    applyStimulus(2, OP_OR, 32'h12340000, 32'h00005678);
    expectRsp(2, 32'h000000ff);
    aluReturn(8'd3, 32'h000000ff);
    checkOutput("simul rsp_valid", 64'(rsp_valid_o), 64'(4'b0100));
    checkOutput("simul ack", 64'(ack_o), 64'(4'b1000));
    req[3] = 1'b0;
    tick();
    checkOutput("client2 regrant", 64'(ack_o), 64'(4'b0100));
    req[2] = 1'b0;
    expectRsp(3, 32'h00f000f0);
    aluReturn(8'd4, 32'h00f000f0);
    expectRsp(2, 32'h12345678);
    aluReturn(8'd3, 32'h12345678);
    tick();
    checkOutput("simul drained", 64'(busy_o), 64'(0));

    $display("[TB] bad key");
    aluReturn(8'd9, 32'hdeadbeef);
    checkOutput("bad key no rsp", 64'(rsp_valid_o), 64'(0));
    checkOutput("bad key err", 64'(err_o), 64'(1));
    clr = 1'b1; tick(); clr = 1'b0;
    checkOutput("err through clr", 64'(err_o), 64'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("err cleared by rst", 64'(err_o), 64'(0));

    $display("[TB] flush with clients busy");
    applyStimulus(0, OP_ADD, 32'h00000001, 32'h00000002);
    applyStimulus(1, OP_ADD, 32'h00000003, 32'h00000004);
    tick();
    checkOutput("flush grant 0", 64'(ack_o), 64'(4'b0001));
    req[0] = 1'b0;
    tick();
    checkOutput("flush grant 1", 64'(ack_o), 64'(4'b0010));
    req[1] = 1'b0;
    checkOutput("flush busy before", 64'(busy_o), 64'(4'b0011));
    clr = 1'b1; tick(); clr = 1'b0;
    checkOutput("flush busy after", 64'(busy_o), 64'(0));
    aluReturn(8'd1, 32'h00000003);
    checkOutput("stale key1 dropped", 64'(rsp_valid_o), 64'(0));
    aluReturn(8'd2, 32'h00000007);
    checkOutput("stale key2 dropped", 64'(rsp_valid_o), 64'(0));
    checkOutput("stale no err", 64'(err_o), 64'(0));

    $display("[TB] issue disabled");
    en = 1'b0;
    req = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("en low key idle", 64'(alu_key_o), 64'(0));
    end
    req = '0;
    en = 1'b1;
    applyStimulus(0, OP_ADD, 32'h00000001, 32'h00000002);
    waitAck(0);
    expectRsp(0, 32'h00000003);
    aluReturn(8'd1, 32'h00000003);
    repeat (2) tick();
    checkOutput("issue queue empty", 64'(issueQ.size()), 64'(0));
    checkOutput("rsp queue empty", 64'(rspQ.size()), 64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
